posit_regime_arbiter: RTL and testbench
=======================================

# posit_regime_arbiter

Two-requester arbiter and output stage for the shared posit regime-decode datapath. It grants one of two valid/ready requesters per cycle using round-robin priority and decodes the granted posit's regime with one shared combinational decoder. The result is registered with a requester tag in a single-entry output stage. It sits between the posit operand front ends (decode port A: divide/sqrt seed path; port B: general unpack path) and their consumers.

## Interface
Parameters:
- BITS, 32, posit width; legal range is 8 to 32.
- ES, 3, exponent field width. Passed through to the decoder; does not affect the regime result.

Ports:
- clk  in  1  clock. One clock domain; all state updates on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- a_valid  in  1  requester A has a posit.
- a_ready  out  1  requester A's posit is accepted this cycle.
- a_data  in  BITS  requester A posit.
- b_valid  in  1  requester B has a posit.
- b_ready  out  1  requester B's posit is accepted this cycle.
- b_data  in  BITS  requester B posit.
- out_valid  out  1  output register holds a result.
- out_ready  in  1  consumer takes the result.
- out_tag  out  1  source of the result: 0 = A, 1 = B.
- out_data  out  BITS  registered copy of the accepted posit.
- out_regime  out  BITS  signed regime value k.
- out_special  out  1  set when data[BITS-2:0] == 0 (zero or NaR).
- gnt_cnt_a  out  16  grant counter for requester A (see Configuration).
- gnt_cnt_b  out  16  grant counter for requester B (see Configuration).

## Operation
Regime rule, decoder is purely combinational on the selected posit:
- r = data[BITS-2].
- m = length of the run of bits equal to r, counted from bit BITS-2 downward, 1 ≤ m ≤ BITS-1.
- If r = 1: k = m-1.
- If r = 0: k = -m.
- A run that reaches bit 0 with no terminator gives m = BITS-1.
- k is sign-extended to BITS.
- data[BITS-1] (the sign bit) is ignored; the posit is not negated first.

Output stage states:
- EMPTY: out_valid = 0.
- FULL: out_valid = 1.
- The stage can accept when `space = !out_valid | out_ready`.

Arbitration:
- Priority pointer `last` holds the tag of the most recent grant; reset value is 1.
- Only one valid: that requester is granted.
- Both valid: the requester ≠ `last` is granted.
- a_ready = grant_A & space; b_ready = grant_B & space. A requester that is not granted sees ready = 0.
- Accept (valid & ready) does all of the following:
  - load out_data, out_regime, out_special, out_tag;
  - set out_valid = 1;
  - set last = tag.
- Consume with no accept (out_valid & out_ready): clear out_valid.
- Simultaneous consume and accept: the new result replaces the old one, out_valid stays 1. Full throughput is one result per cycle.
- FULL and out_ready = 0: both readys are 0; all output registers hold.

Requester rules:
- A requester holds valid and data stable until accepted.
- The arbiter does not require this, but outputs are undefined if data changes while valid is high and ready is low.

Reset:
- out_valid = 0, out_tag = 0, out_data = 0, out_regime = 0, out_special = 0, last = 1, both counters = 0.
- Reset asserted mid-transfer discards any held result; no accept occurs in a reset cycle (readys are forced to 0 while rst = 1).

## Timing
- Latency: one cycle from accept to out_valid.
- a_ready and b_ready are combinational from a_valid, b_valid, out_valid, out_ready and `last`. There is no combinational path from a_data or b_data to any ready.
- out_* are register outputs only.
- Fairness: with both requesters continuously valid and out_ready = 1, grants alternate A, B, A, B, starting with A after reset.

## Configuration
- POSIT_ARB_STATS_EN defined:
  - gnt_cnt_a and gnt_cnt_b each increment by 1 on every accept from their requester.
  - Each counter saturates at 0xFFFF.
  - Both counters clear on reset.
- Not defined:
  - No counter registers are built.
  - gnt_cnt_a and gnt_cnt_b are tied to 0.
  - All other behaviour is identical.

## Test plan
All scenarios use BITS = 32.
- Regime values: A alone, out_ready = 1, sends 0x40000000, 0x20000000, 0x7FFFFFFF, 0x00000001, 0x00000000 -> out_regime = 0, -1, 30, -30, -31 respectively; out_special = 1 only for 0x00000000; each result appears one cycle after accept with out_tag = 0.
- Round-robin: A and B both valid for 6 cycles, out_ready = 1 -> out_tag sequence 0,1,0,1,0,1; with POSIT_ARB_STATS_EN, gnt_cnt_a = 3 and gnt_cnt_b = 3.
- Backpressure: out_ready held 0 for 4 cycles with A valid -> out_valid = 1 and out_data stable; a_ready = 0 after the first accept. Release out_ready -> next accept in that same cycle, no result lost or duplicated.
- Simultaneous consume/accept: FULL, out_ready = 1, B valid with 0xC0000000 -> out_data = 0xC0000000, out_regime = 0 next cycle, out_valid stays 1.
- Reset mid-operation: rst = 1 while FULL and A valid -> next cycle out_valid = 0, a_ready = 0 during reset; after rst = 0 with both valid, A is granted first.
- Saturation: with POSIT_ARB_STATS_EN, 65540 A-only accepts -> gnt_cnt_a = 0xFFFF; without the macro, both counters read 0 throughout.

Source files
------------

// File: rtl/posit_regime_arbiter.sv
// posit_regime_arbiter
//
// Two-requester round-robin arbiter in front of one shared posit regime
// decoder. The granted posit is decoded combinationally, and the result is
// captured with a requester tag in a single-entry output register.
// Port A feeds the divide/sqrt seed path. Port B feeds the general unpack path.
//
// Parameters:
//   BITS  posit width, 8..32
//   ES    exponent field width; carried for interface compatibility only,
//         because the regime does not depend on it
//
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   a_valid/a_ready/a_data         requester A handshake and posit
//   b_valid/b_ready/b_data         requester B handshake and posit
//   out_valid/out_ready            output register handshake
//   out_tag                        source of the result (0 = A, 1 = B)
//   out_data                       registered copy of the accepted posit
//   out_regime                     signed regime k, sign-extended to BITS
//   out_special                    accepted posit was zero or NaR
//   gnt_cnt_a/gnt_cnt_b            saturating grant counters
//
// Build option:
//   POSIT_ARB_STATS_EN  when defined, builds the 16-bit saturating grant
//                       counters. When undefined, both counters read 0.
module posit_regime_arbiter #(
  parameter int BITS = 32,
  parameter int ES   = 3
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            a_valid,
  output logic            a_ready,
  input  logic [BITS-1:0] a_data,
  input  logic            b_valid,
  output logic            b_ready,
  input  logic [BITS-1:0] b_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic            out_tag,
  output logic [BITS-1:0] out_data,
  output logic [BITS-1:0] out_regime,
  output logic            out_special,
  output logic [15:0]     gnt_cnt_a,
  output logic [15:0]     gnt_cnt_b
);

  // Wide enough to hold a run length of up to BITS-1.
  localparam int CW = $clog2(BITS) + 1;

  logic            out_valid_reg;
  logic            out_tag_reg;
  logic [BITS-1:0] out_data_reg;
  logic [BITS-1:0] out_regime_reg;
  logic            out_special_reg;
  logic            last_reg;

  logic            space;
  logic            grant_a;
  logic            grant_b;
  logic            accept;
  logic [BITS-1:0] sel_data;
  logic            regime_bit;
  logic [CW-1:0]   run_len;
  logic [BITS-1:0] regime_k;
  logic            special;

  // ES is not used by the regime decoder.
  logic unused_cfg;
  assign unused_cfg = (ES < 0);

  // Grant decisions use only the valids and the pointer, never the data.
  // When both requesters are valid, the one that was not granted last wins.
  assign space   = !out_valid_reg || out_ready;
  assign grant_a = a_valid && (!b_valid || last_reg);
  assign grant_b = b_valid && (!a_valid || !last_reg);
  assign a_ready = grant_a && space && !rst;
  assign b_ready = grant_b && space && !rst;
  assign accept  = a_ready || b_ready;

  assign sel_data   = grant_b ? b_data : a_data;
  assign regime_bit = sel_data[BITS-2];
  assign special    = (sel_data[BITS-2:0] == '0);

  // Find the length of the run of bits equal to regime_bit, starting at
  // BITS-2. The first bit always belongs to the run. Once the run is broken,
  // the remaining bits do not contribute.
  always_comb begin
    logic running;
    running = 1'b1;
    run_len = CW'(1);
    for (int i = BITS - 3; i >= 0; i--) begin
      running = running && (sel_data[i] == regime_bit);
      run_len = run_len + CW'(running);
    end
  end

  // k = m-1 for a run of ones, and k = -m for a run of zeros.
  assign regime_k = regime_bit ? (BITS'(run_len) - BITS'(1))
                               : (BITS'(0) - BITS'(run_len));

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_reg   <= 1'b0;
      out_tag_reg     <= 1'b0;
      out_data_reg    <= '0;
      out_regime_reg  <= '0;
      out_special_reg <= 1'b0;
      last_reg        <= 1'b1;
    end else if (accept) begin
      // This also covers a simultaneous consume: the new result replaces
      // the old one.
      out_valid_reg   <= 1'b1;
      out_tag_reg     <= b_ready;
      out_data_reg    <= sel_data;
      out_regime_reg  <= regime_k;
      out_special_reg <= special;
      last_reg        <= b_ready;
    end else if (out_ready) begin
      out_valid_reg   <= 1'b0;
    end
  end

  assign out_valid   = out_valid_reg;
  assign out_tag     = out_tag_reg;
  assign out_data    = out_data_reg;
  assign out_regime  = out_regime_reg;
  assign out_special = out_special_reg;

`ifdef POSIT_ARB_STATS_EN
  logic [15:0] cnt_a_reg;
  logic [15:0] cnt_b_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_a_reg <= '0;
      cnt_b_reg <= '0;
    end else begin
      if (a_ready && cnt_a_reg != 16'hFFFF) cnt_a_reg <= cnt_a_reg + 16'd1;
      if (b_ready && cnt_b_reg != 16'hFFFF) cnt_b_reg <= cnt_b_reg + 16'd1;
    end
  end

  assign gnt_cnt_a = cnt_a_reg;
  assign gnt_cnt_b = cnt_b_reg;
`else
  assign gnt_cnt_a = 16'd0;
  assign gnt_cnt_b = 16'd0;
`endif

endmodule

// File: tb/tb_posit_regime_arbiter.sv
// Testbench for posit_regime_arbiter, with BITS = 32.
//
// A transaction-level model runs on the rising edge. It predicts grants,
// output occupancy and counters, and it pushes each expected result into a
// scoreboard queue. A monitor on the falling edge compares the DUT outputs
// against the head of that queue, and pops the head when the consumer takes
// the result.
module tb_posit_regime_arbiter;

  localparam int BITS = 32;

  typedef struct {
    logic        tag;
    logic [31:0] data;
    logic [31:0] regime;
    logic        special;
  } item_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        a_valid = 1'b0;
  logic        a_ready;
  logic [31:0] a_data = '0;
  logic        b_valid = 1'b0;
  logic        b_ready;
  logic [31:0] b_data = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic        out_tag;
  logic [31:0] out_data;
  logic [31:0] out_regime;
  logic        out_special;
  logic [15:0] gnt_cnt_a;
  logic [15:0] gnt_cnt_b;

  int errors = 0;
  int checks = 0;

  item_t       sb[$];
  logic [31:0] a_q[$];
  logic [31:0] b_q[$];
  logic        tag_log[$];
  bit          stream_a = 1'b0;

  // Model state.
  bit m_full = 1'b0;
  bit m_last = 1'b1;
  bit acc_a  = 1'b0;
  bit acc_b  = 1'b0;
  int m_cnt_a = 0;
  int m_cnt_b = 0;

  posit_regime_arbiter #(.BITS(BITS), .ES(3)) dut (
    .clk(clk), .rst(rst),
    .a_valid(a_valid), .a_ready(a_ready), .a_data(a_data),
    .b_valid(b_valid), .b_ready(b_ready), .b_data(b_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_tag(out_tag),
    .out_data(out_data), .out_regime(out_regime), .out_special(out_special),
    .gnt_cnt_a(gnt_cnt_a), .gnt_cnt_b(gnt_cnt_b)
  );

  always #5 clk = ~clk;

  // Regime computed directly from the definition: walk down from bit 30
  // while the bits match bit 30.
  function automatic logic [31:0] ref_regime(input logic [31:0] p);
    int m;
    logic r;
    r = p[30];
    m = 0;
    for (int i = 30; i >= 0; i--) begin
      if (p[i] != r) break;
      m++;
    end
    return r ? 32'(m - 1) : 32'(-m);
  endfunction

  function automatic void exp_ready(output bit ea, output bit eb);
    bit space;
    space = !m_full || out_ready;
    ea = a_valid && (!b_valid || m_last) && space && !rst;
    eb = b_valid && (!a_valid || !m_last) && space && !rst;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
    end
  endtask

  // Reference model: it sees only bench-driven inputs and its own state.
  always @(posedge clk) begin
    bit ea, eb;
    item_t it;
    if (rst) begin
      m_full = 1'b0;
      m_last = 1'b1;
      acc_a = 1'b0;
      acc_b = 1'b0;
      m_cnt_a = 0;
      m_cnt_b = 0;
      sb.delete();
    end else begin
      exp_ready(ea, eb);
      acc_a = ea;
      acc_b = eb;
      if (ea || eb) begin
        it.tag     = eb;
        it.data    = eb ? b_data : a_data;
        it.regime  = ref_regime(it.data);
        it.special = (it.data[30:0] == 31'd0);
        sb.push_back(it);
        $display("accept tag=%0d data=%h exp_regime=%0d", it.tag, it.data, $signed(it.regime));
        m_full = 1'b1;
        m_last = eb;
`ifdef POSIT_ARB_STATS_EN
        if (ea && m_cnt_a < 65535) m_cnt_a++;
        if (eb && m_cnt_b < 65535) m_cnt_b++;
`endif
      end else if (out_ready) begin
        m_full = 1'b0;
      end
    end
  end

  // Requester drivers. Each requester holds valid and data until the model
  // says it was accepted.
  always @(posedge clk) begin
    #1;
    if (a_valid && acc_a) a_valid = 1'b0;
    if (b_valid && acc_b) b_valid = 1'b0;
    if (!a_valid) begin
      if (stream_a) begin
        a_valid = 1'b1;
        a_data = $urandom;
      end else if (a_q.size() > 0) begin
        a_valid = 1'b1;
        a_data = a_q.pop_front();
      end
    end
    if (!b_valid && b_q.size() > 0) begin
      b_valid = 1'b1;
      b_data = b_q.pop_front();
    end
  end

  // Monitor, sampling on the falling edge.
  always @(negedge clk) begin
    bit ea, eb;
    item_t h;
    exp_ready(ea, eb);
    chk("out_valid", 32'(out_valid), 32'(m_full));
    chk("a_ready", 32'(a_ready), 32'(ea));
    chk("b_ready", 32'(b_ready), 32'(eb));
    chk("gnt_cnt_a", 32'(gnt_cnt_a), 32'(m_cnt_a));
    chk("gnt_cnt_b", 32'(gnt_cnt_b), 32'(m_cnt_b));
    if (out_valid === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL result_unexpected: got data=%h, expected no result", out_data);
      end else begin
        h = sb[0];
        chk("out_tag", 32'(out_tag), 32'(h.tag));
        chk("out_data", out_data, h.data);
        chk("out_regime", out_regime, h.regime);
        chk("out_special", 32'(out_special), 32'(h.special));
        if (out_ready) begin
          $display("result tag=%0d data=%h regime=%0d special=%0d",
                   out_tag, out_data, $signed(out_regime), out_special);
          tag_log.push_back(out_tag);
          void'(sb.pop_front());
        end
      end
    end
  end

  task automatic cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drain(input string name, input int limit);
    int n;
    n = 0;
    while ((a_q.size() > 0 || b_q.size() > 0 || a_valid || b_valid || m_full) && n < limit) begin
      cycles(1);
      n++;
    end
    if (n >= limit) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: still busy after %0d cycles, required idle", name, limit);
    end
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst = 1'b1;
    cycles(2);
    rst = 1'b0;
  endtask

  initial begin
    logic [31:0] regime_vals [5];
    logic [31:0] d;
    regime_vals = '{32'h40000000, 32'h20000000, 32'h7FFFFFFF, 32'h00000001, 32'h00000000};

    cycles(3);
    rst = 1'b0;
    @(negedge clk);
    chk("reset_out_data", out_data, 32'h0);
    chk("reset_out_regime", out_regime, 32'h0);
    chk("reset_out_tag", 32'(out_tag), 32'h0);
    chk("reset_out_special", 32'(out_special), 32'h0);
    cycles(1);

    // Directed regime values from requester A.
    foreach (regime_vals[i]) a_q.push_back(regime_vals[i]);
    drain("regime", 50);

    // Round robin after reset: the order must be A first, then alternate.
    do_reset();
    tag_log.delete();
    for (int i = 0; i < 3; i++) begin
      a_q.push_back(32'h10000000 << i);
      b_q.push_back(32'h60000000 >> i);
    end
    drain("round_robin", 50);
    chk("rr_count", 32'(tag_log.size()), 32'd6);
    for (int i = 0; i < 6 && i < tag_log.size(); i++)
      chk("rr_tag", 32'(tag_log[i]), 32'(i % 2));
`ifdef POSIT_ARB_STATS_EN
    chk("rr_cnt_a", 32'(gnt_cnt_a), 32'd3);
    chk("rr_cnt_b", 32'(gnt_cnt_b), 32'd3);
`endif

    // Backpressure: the held result stays stable, and A is not granted.
    out_ready = 1'b0;
    a_q.push_back(32'h08000000);
    a_q.push_back(32'h7F000000);
    cycles(4);
    @(negedge clk);
    chk("bp_out_valid", 32'(out_valid), 32'd1);
    chk("bp_a_ready", 32'(a_ready), 32'd0);
    chk("bp_out_data", out_data, 32'h08000000);
    cycles(1);
    out_ready = 1'b1;
    drain("backpressure", 50);

    // Simultaneous consume and accept from B.
    a_q.push_back(32'h12345678);
    cycles(2);
    b_q.push_back(32'hC0000000);
    drain("consume_accept", 50);

    // Reset while the stage is full and A is still waiting.
    out_ready = 1'b0;
    a_q.push_back(32'h03000000);
    a_q.push_back(32'h5A5A5A5A);
    cycles(4);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_a_ready", 32'(a_ready), 32'd0);
    cycles(1);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    tag_log.delete();
    out_ready = 1'b1;
    b_q.push_back(32'hFFFFFFFF);
    drain("post_reset", 50);
    chk("rst_first_tag", tag_log.size() > 0 ? 32'(tag_log[0]) : 32'hDEAD, 32'd0);

    // Random traffic with random backpressure.
    for (int c = 0; c < 400; c++) begin
      if (a_q.size() < 3 && $urandom_range(0, 2) == 0) begin
        d = $urandom >> $urandom_range(0, 31);
        if ($urandom_range(0, 1) == 1) d = ~d;
        a_q.push_back(d);
      end
      if (b_q.size() < 3 && $urandom_range(0, 2) == 0) begin
        d = $urandom >> $urandom_range(0, 31);
        if ($urandom_range(0, 1) == 1) d = ~d;
        b_q.push_back(d);
      end
      out_ready = ($urandom_range(0, 3) != 0);
      cycles(1);
    end
    out_ready = 1'b1;
    drain("random", 100);

    // Counter saturation under continuous A traffic.
    stream_a = 1'b1;
    cycles(65540);
    stream_a = 1'b0;
    drain("saturation", 50);
`ifdef POSIT_ARB_STATS_EN
    chk("sat_cnt_a", 32'(gnt_cnt_a), 32'h0000FFFF);
`else
    chk("sat_cnt_a", 32'(gnt_cnt_a), 32'h0);
    chk("sat_cnt_b", 32'(gnt_cnt_b), 32'h0);
`endif
    chk("sb_empty", 32'(sb.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
